data_memory_arbiter: RTL
========================

Name: data_memory_arbiter

Overview:
Shares the single-port Data_Memory between two requesters: port 0 is the processor load/store stage and port 1 is the DMA/debug loader. Each cycle it arbitrates round-robin, drives the memory's write-enable, address and write-data, and returns registered read data with a one-cycle response pulse. A lock mechanism supports back-to-back read-modify-write sequences, and a lock timeout bounds how long one requester can starve the other.

Parameters:
ADDR_WIDTH, 32, width of request address and Mem_Address
DATA_WIDTH, 32, width of write/read data
LOCK_LIMIT, 8, maximum consecutive locked cycles before the lock is forcibly released (≥1)

Ports:
Clk  in  1  single clock, rising edge
Reset_n  in  1  asynchronous, active-low reset
Req_Valid_0 / Req_Valid_1  in  1  request present
Req_Write_0 / Req_Write_1  in  1  1=write, 0=read
Req_Lock_0 / Req_Lock_1  in  1  keep ownership after this transfer
Req_Address_0 / Req_Address_1  in  ADDR_WIDTH  byte address
Req_Write_Data_0 / Req_Write_Data_1  in  DATA_WIDTH  store data
Req_Ready_0 / Req_Ready_1  out  1  transfer accepted this cycle (grant)
Resp_Valid_0 / Resp_Valid_1  out  1  one-cycle completion pulse
Resp_Read_Data_0 / Resp_Read_Data_1  out  DATA_WIDTH  registered read data
Mem_Write  out  1  to Data_Memory Memory_Write
Mem_Address  out  ADDR_WIDTH  to Data_Memory ALU_Result
Mem_Write_Data  out  DATA_WIDTH  to Data_Memory Memory_Write_Data
Mem_Read_Data  in  DATA_WIDTH  from Data_Memory Read_Data (combinational read)

Behaviour:
- Reset (Reset_n=0, asynchronous): state=ARB, Last_Grant=1, Lock_Count=0, Resp_Valid_*=0, Resp_Read_Data_*=0. While reset is low, Req_Ready_* and Mem_Write are forced to 0.
- A transfer occurs on a cycle where Req_Valid_i=1 and Req_Ready_i=1. Req_Ready_i is combinational from the valids and the state. At most one Ready is high per cycle.
- State ARB:
  - Only one valid → grant it.
  - Both valid → grant the requester ≠ Last_Grant.
  - Neither valid → no grant.
- State LOCK0/LOCK1: only the owner can be granted. The other requester's Ready=0 even if the owner is idle.
- Memory drive:
  - Granted: Mem_Address and Mem_Write_Data come from the granted port; Mem_Write = Req_Write of the granted port.
  - No grant: Mem_Write=0, Mem_Address=0, Mem_Write_Data=0.
- Response latency is 1 cycle. At the rising edge ending a transfer on port i:
  - Resp_Valid_i is set for exactly the next cycle.
  - On a read, Resp_Read_Data_i captures Mem_Read_Data. On a write it holds its previous value.
- Last_Grant updates to i on every transfer by port i.
- Transitions:
  - ARB→LOCKi: transfer on port i with Req_Lock_i=1; Lock_Count←1.
  - LOCKi→LOCKi: transfer with Req_Lock_i=1 → Lock_Count+1. Idle cycle (owner has no valid) → Lock_Count+1.
  - LOCKi→ARB: transfer with Req_Lock_i=0, or Lock_Count==LOCK_LIMIT at a clock edge (timeout). On timeout, Last_Grant←i so the other requester wins the next tie.
- Lock_Count saturates and never wraps. It resets to 0 on entering ARB.
- Write-then-read to the same address on consecutive grants returns the new data, because the memory writes on the edge and reads combinationally.
- Reset asserted mid-lock or mid-response clears all state immediately. A pending Resp_Valid is lost.

Decomposition:
- Shared package (data_memory_pkg):
  - state encoding ARB=2'd0, LOCK0=2'd1, LOCK1=2'd2
  - requester index constants PORT_CORE=0, PORT_DMA=1
  - default widths
- One sub-module is natural: rr_arbiter2. It is a combinational 2-way round-robin grant from valids, Last_Grant and a lock mask.
- The FSM, counter and response registers stay in the top level.

Test Plan:
- Port 0 writes 45 to address 64, then port 1 writes 100 to address 128. Then port 0 reads 64 and port 1 reads 128 → Resp_Read_Data_0=45 and Resp_Read_Data_1=100, each Resp_Valid one cycle after its grant.
- Both ports read continuously after reset → grants alternate 0,1,0,1; the first grant is port 0.
- Port 1 locks: read 128 (Lock=1), then write 101 to 128 (Lock=0), while port 0 is valid throughout → port 0 Ready=0 for both cycles and is granted on the third cycle. A following read of 128 returns 101.
- Port 0 holds Lock=1 continuously with LOCK_LIMIT=8 and port 1 valid → port 1 is granted exactly on the cycle after 8 locked cycles.
- Reset_n pulsed low while in LOCK1 with Resp_Valid_1 pending → all outputs are immediately 0. After release, a tie grants port 0.
- Neither port valid → Mem_Write=0 and Mem_Address=0, and no Resp_Valid is asserted.

Source files
------------

// File: rtl/data_memory_pkg.sv
// rtl/data_memory_pkg.sv - shared types and constants for the data memory arbiter
package data_memory_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 32;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_LOCK_LIMIT = 8;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DMA  = 1'b1;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arbState_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - combinational two-way round-robin grant with lock mask
module rr_arbiter2
  import data_memory_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       lastGrant,
  input  logic [1:0] lockMask,
  output logic [1:0] grant
);

  logic [1:0] eligible;

  // Lone eligible requester wins; on a tie the one not served last wins.
  always_comb begin
    eligible = valid & lockMask;
    grant    = eligible;
    if (eligible == 2'b11) begin
      grant = (lastGrant == PORT_CORE) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// rtl/data_memory_arbiter.sv - shares single-port Data_Memory between core and DMA
module data_memory_arbiter
  import data_memory_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int LOCK_LIMIT = DEFAULT_LOCK_LIMIT
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  Req_Valid_0,
  input  logic                  Req_Valid_1,
  input  logic                  Req_Write_0,
  input  logic                  Req_Write_1,
  input  logic                  Req_Lock_0,
  input  logic                  Req_Lock_1,
  input  logic [ADDR_WIDTH-1:0] Req_Address_0,
  input  logic [ADDR_WIDTH-1:0] Req_Address_1,
  input  logic [DATA_WIDTH-1:0] Req_Write_Data_0,
  input  logic [DATA_WIDTH-1:0] Req_Write_Data_1,
  output logic                  Req_Ready_0,
  output logic                  Req_Ready_1,
  output logic                  Resp_Valid_0,
  output logic                  Resp_Valid_1,
  output logic [DATA_WIDTH-1:0] Resp_Read_Data_0,
  output logic [DATA_WIDTH-1:0] Resp_Read_Data_1,
  output logic                  Mem_Write,
  output logic [ADDR_WIDTH-1:0] Mem_Address,
  output logic [DATA_WIDTH-1:0] Mem_Write_Data,
  input  logic [DATA_WIDTH-1:0] Mem_Read_Data
);

  localparam int CNT_W = $clog2(LOCK_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(LOCK_LIMIT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  arbState_t        state, stateNext;
  logic             lastGrant, lastGrantNext;
  logic [CNT_W-1:0] lockCount, lockCountNext, lockCountInc;
  logic [1:0]       lockMask, rawGrant, grant;
  logic             timeout;

  // While locked only the owner may be considered.
  always_comb begin
    lockMask = 2'b11;
    case (state)
      LOCK0:   lockMask = 2'b01;
      LOCK1:   lockMask = 2'b10;
      default: lockMask = 2'b11;
    endcase
  end

  rr_arbiter2 u_rr_arbiter2 (
    .valid     ({Req_Valid_1, Req_Valid_0}),
    .lastGrant (lastGrant),
    .lockMask  (lockMask),
    .grant     (rawGrant)
  );

  // Nothing is granted while reset is held, so the memory never sees a stray write.
  assign grant       = Reset_n ? rawGrant : 2'b00;
  assign Req_Ready_0 = grant[0];
  assign Req_Ready_1 = grant[1];

  // Steer the granted port onto the memory bus; park at zero when idle.
  always_comb begin
    Mem_Write      = 1'b0;
    Mem_Address    = '0;
    Mem_Write_Data = '0;
    if (grant[0]) begin
      Mem_Write      = Req_Write_0;
      Mem_Address    = Req_Address_0;
      Mem_Write_Data = Req_Write_Data_0;
    end else if (grant[1]) begin
      Mem_Write      = Req_Write_1;
      Mem_Address    = Req_Address_1;
      Mem_Write_Data = Req_Write_Data_1;
    end
  end

  assign timeout      = (lockCount == CNT_LIMIT);
  assign lockCountInc = timeout ? lockCount : lockCount + CNT_ONE;

  // Next-state logic for lock ownership, lock counter and round-robin history.
  always_comb begin
    stateNext     = state;
    lockCountNext = lockCount;
    lastGrantNext = lastGrant;
    if (grant[0]) begin
      lastGrantNext = PORT_CORE;
    end else if (grant[1]) begin
      lastGrantNext = PORT_DMA;
    end
    case (state)
      ARB: begin
        if (grant[0] && Req_Lock_0) begin
          stateNext     = LOCK0;
          lockCountNext = CNT_ONE;
        end else if (grant[1] && Req_Lock_1) begin
          stateNext     = LOCK1;
          lockCountNext = CNT_ONE;
        end
      end
      LOCK0: begin
        if (timeout) begin
          stateNext     = ARB;
          lockCountNext = '0;
          lastGrantNext = PORT_CORE;
        end else if (grant[0] && !Req_Lock_0) begin
          stateNext     = ARB;
          lockCountNext = '0;
        end else begin
          lockCountNext = lockCountInc;
        end
      end
      LOCK1: begin
        if (timeout) begin
          stateNext     = ARB;
          lockCountNext = '0;
          lastGrantNext = PORT_DMA;
        end else if (grant[1] && !Req_Lock_1) begin
          stateNext     = ARB;
          lockCountNext = '0;
        end else begin
          lockCountNext = lockCountInc;
        end
      end
      default: begin
        stateNext     = ARB;
        lockCountNext = '0;
      end
    endcase
  end

  // Arbitration state register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= ARB;
      lastGrant <= PORT_DMA;
      lockCount <= '0;
    end else begin
      state     <= stateNext;
      lastGrant <= lastGrantNext;
      lockCount <= lockCountNext;
    end
  end

  // One-cycle response pulse; read data captured only on reads.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Resp_Valid_0     <= 1'b0;
      Resp_Valid_1     <= 1'b0;
      Resp_Read_Data_0 <= '0;
      Resp_Read_Data_1 <= '0;
    end else begin
      Resp_Valid_0 <= grant[0];
      Resp_Valid_1 <= grant[1];
      if (grant[0] && !Req_Write_0) begin
        Resp_Read_Data_0 <= Mem_Read_Data;
      end
      if (grant[1] && !Req_Write_1) begin
        Resp_Read_Data_1 <= Mem_Read_Data;
      end
    end
  end

endmodule
